oam_dma: RTL

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma_pkg.sv | 25 ++
 rtl/oam_dma.sv | 132 +++++++++++++
 2 files changed

// File: rtl/oam_dma_pkg.sv
// Shared definitions for the OAM DMA engine: FSM state encoding, default
// bus addresses and a small state helper.
package oam_dma_pkg;

   // Transfer sequencer states, fixed encoding.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_ALIGN = 3'd2,
      ST_READ  = 3'd3,
      ST_WRITE = 3'd4
   } dma_state_t;

   // CPU write address that starts a transfer (page register).
   localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;

   // Sprite memory data port that receives every DMA write.
   localparam logic [15:0] OAMDATA_ADDR  = 16'h2004;

   // The engine owns the bus and stalls the CPU in every state except IDLE.
   function automatic logic is_busy(input dma_state_t s);
      return (s != ST_IDLE);
   endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to the trigger address latches a source page
// and copies XFER_LEN bytes from {page,count} to OAMDATA_ADDR, one byte per
// READ/WRITE pair, while holding the CPU stalled.
// Build option: define OAM_DMA_ALIGN_EN to insert one ALIGN cycle after HALT
// when the free-running parity flop is 1 (odd-cycle start).
module oam_dma
   import oam_dma_pkg::dma_state_t;
   import oam_dma_pkg::ST_IDLE;
   import oam_dma_pkg::ST_HALT;
   import oam_dma_pkg::ST_ALIGN;
   import oam_dma_pkg::ST_READ;
   import oam_dma_pkg::ST_WRITE;
   import oam_dma_pkg::is_busy;
#(
   parameter logic [15:0] DMA_TRIG_ADDR = oam_dma_pkg::DMA_TRIG_ADDR,
   parameter logic [15:0] OAMDATA_ADDR  = oam_dma_pkg::OAMDATA_ADDR,
   parameter int unsigned XFER_LEN      = 256
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_write,
   input  logic [7:0]  mem_rdata,
   output logic        stall,
   output logic        dma_active,
   output logic [15:0] dma_addr,
   output logic [7:0]  dma_wdata,
   output logic        dma_read,
   output logic        dma_write
);

`ifdef OAM_DMA_ALIGN_EN
   localparam logic ALIGN_EN = 1'b1;
`else
   localparam logic ALIGN_EN = 1'b0;
`endif

   // Index of the final byte; the transfer ends after writing this one.
   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   dma_state_t  state_q, state_d;
   logic [7:0]  page_q,  page_d;
   logic [7:0]  count_q, count_d;
   logic [7:0]  data_q,  data_d;
   logic        parity_q, parity_d;
   logic        trigger;
   logic        busy;

   // A trigger is only a write to the page register; reads never start a transfer.
   always_comb begin
      trigger = cpu_write && (cpu_addr == DMA_TRIG_ADDR);
   end

   // Next-state logic for the sequencer, page/count registers, data latch and parity.
   always_comb begin
      state_d  = state_q;
      page_d   = page_q;
      count_d  = count_q;
      data_d   = data_q;
      parity_d = ~parity_q;
      case (state_q)
         ST_IDLE: begin
            if (trigger) begin
               state_d = ST_HALT;
               page_d  = cpu_wdata;
               count_d = 8'd0;
            end
         end
         ST_HALT: begin
            state_d = (ALIGN_EN && parity_q) ? ST_ALIGN : ST_READ;
         end
         ST_ALIGN: begin
            state_d = ST_READ;
         end
         ST_READ: begin
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            data_d  = mem_rdata;
            count_d = count_q + 8'd1;
            state_d = (count_q == LAST_IDX) ? ST_IDLE : ST_READ;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any transfer outright.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         page_q   <= 8'd0;
         count_q  <= 8'd0;
         data_q   <= 8'd0;
         parity_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         page_q   <= page_d;
         count_q  <= count_d;
         data_q   <= data_d;
         parity_q <= parity_d;
      end
   end

   // Bus outputs decoded from the current state so reset clears them at once.
   always_comb begin
      busy       = is_busy(state_q);
      stall      = busy;
      dma_active = busy;
      dma_read   = 1'b0;
      dma_write  = 1'b0;
      dma_addr   = 16'h0000;
      dma_wdata  = data_q;
      case (state_q)
         ST_READ: begin
            dma_read = 1'b1;
            dma_addr = {page_q, count_q};
         end
         ST_WRITE: begin
            dma_write = 1'b1;
            dma_addr  = OAMDATA_ADDR;
            dma_wdata = mem_rdata;
         end
         default: begin
            dma_read = 1'b0;
         end
      endcase
   end

endmodule
